// File: rtl/spi_ram_burst.sv
// -----------------------------------------------------------------------------
// spi_ram_burst
//   Single-port word RAM that sits behind an SPI slave. It accepts parallel
//   command words (opcode + payload) and returns read data for serialisation.
//   Independent write and read pointers, with optional auto-increment, let a
//   host burst through memory without re-sending an address for every word.
//
// Command word din[DATA_W+1:0]: opcode = din[DATA_W+1:DATA_W]
//   2'b00 SET_WA : wr_ptr <= payload[ADDR_SIZE-1:0]
//   2'b01 WRITE  : mem[wr_ptr] <= payload, then wr_ptr advances if AUTO_INC
//   2'b10 SET_RA : rd_ptr <= payload[ADDR_SIZE-1:0]
//   2'b11 READ   : next cycle dout <= mem[rd_ptr] with a tx_valid pulse,
//                  then rd_ptr advances if AUTO_INC
//   A pointer at MEM_DEPTH-1 or beyond advances to 0. An out-of-range WRITE
//   is dropped. An out-of-range READ returns 0 and still pulses tx_valid.
//
// Ports
//   clk         in   system clock, rising edge
//   rst_n       in   asynchronous active-low reset (memory is not cleared)
//   rx_valid    in   din carries a command this cycle
//   din         in   [DATA_W+1:0] command word
//   dout        out  [DATA_W-1:0] read data, held until the next READ
//   tx_valid    out  one-cycle strobe, dout valid
//   parity_err  out  read parity mismatch, qualified by tx_valid
//                    (present only when RAM_PARITY_EN is defined)
//
// Build option: define RAM_PARITY_EN to store an even-parity bit with each
// word and check it on read. Test hook in that build: flipping r_par[addr]
// hierarchically corrupts the stored parity bit of one word.
// -----------------------------------------------------------------------------
module spi_ram_burst #(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8,
  parameter int DATA_W    = 8,
  parameter int AUTO_INC  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_valid,
  input  logic [DATA_W+1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              tx_valid
`ifdef RAM_PARITY_EN
  ,
  output logic              parity_err
`endif
);

  typedef enum logic [1:0] {
    OP_SET_WA = 2'b00,
    OP_WRITE  = 2'b01,
    OP_SET_RA = 2'b10,
    OP_READ   = 2'b11
  } op_e;

  // One extra bit so that MEM_DEPTH == 2**ADDR_SIZE is representable.
  localparam logic [ADDR_SIZE:0]   DEPTH_L = MEM_DEPTH[ADDR_SIZE:0];
  localparam logic [ADDR_SIZE:0]   LAST_L  = DEPTH_L - 1'b1;
  localparam logic [ADDR_SIZE-1:0] ONE_L   = {{(ADDR_SIZE-1){1'b0}}, 1'b1};

  logic [DATA_W-1:0]    r_mem [MEM_DEPTH];
`ifdef RAM_PARITY_EN
  logic                 r_par [MEM_DEPTH];
  logic                 r_parity_err;
`endif

  logic [ADDR_SIZE-1:0] r_wr_ptr;
  logic [ADDR_SIZE-1:0] r_rd_ptr;
  logic [DATA_W-1:0]    r_dout;
  logic                 r_tx_valid;

  op_e                  w_op;
  logic                 w_wr_in_range;
  logic                 w_rd_in_range;
  logic                 w_do_write;
  logic [ADDR_SIZE-1:0] w_wr_next;
  logic [ADDR_SIZE-1:0] w_rd_next;

  assign w_op          = op_e'(din[DATA_W+1:DATA_W]);
  assign w_wr_in_range = ({1'b0, r_wr_ptr} < DEPTH_L);
  assign w_rd_in_range = ({1'b0, r_rd_ptr} < DEPTH_L);
  assign w_do_write    = rx_valid && (w_op == OP_WRITE) && w_wr_in_range;

  // Anything at or past the last word wraps to 0, so an out-of-range pointer
  // re-enters the valid window on its next access.
  assign w_wr_next = ({1'b0, r_wr_ptr} >= LAST_L) ? '0 : r_wr_ptr + ONE_L;
  assign w_rd_next = ({1'b0, r_rd_ptr} >= LAST_L) ? '0 : r_rd_ptr + ONE_L;

  // Storage has no reset so its contents survive rst_n.
  always_ff @(posedge clk) begin
    if (w_do_write) begin
      r_mem[r_wr_ptr] <= din[DATA_W-1:0];
`ifdef RAM_PARITY_EN
      r_par[r_wr_ptr] <= ^din[DATA_W-1:0];
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_dout     <= '0;
      r_tx_valid <= 1'b0;
`ifdef RAM_PARITY_EN
      r_parity_err <= 1'b0;
`endif
    end else begin
      r_tx_valid <= 1'b0;
`ifdef RAM_PARITY_EN
      r_parity_err <= 1'b0;
`endif
      if (rx_valid) begin
        unique case (w_op)
          OP_SET_WA: r_wr_ptr <= din[ADDR_SIZE-1:0];
          OP_WRITE: begin
            if (AUTO_INC != 0) r_wr_ptr <= w_wr_next;
          end
          OP_SET_RA: r_rd_ptr <= din[ADDR_SIZE-1:0];
          OP_READ: begin
            r_tx_valid <= 1'b1;
            r_dout     <= w_rd_in_range ? r_mem[r_rd_ptr] : '0;
`ifdef RAM_PARITY_EN
            r_parity_err <= w_rd_in_range &&
                            ((^r_mem[r_rd_ptr]) != r_par[r_rd_ptr]);
`endif
            if (AUTO_INC != 0) r_rd_ptr <= w_rd_next;
          end
          default: ;
        endcase
      end
    end
  end

  assign dout     = r_dout;
  assign tx_valid = r_tx_valid;
`ifdef RAM_PARITY_EN
  assign parity_err = r_parity_err;
`endif

endmodule

// File: tb/tb_spi_ram_burst.sv
module tb_spi_ram_burst;

  localparam int N = 3;  // 0: depth 256 inc, 1: depth 256 hold, 2: depth 200 inc

  logic       clk;
  logic       rst_n;
  logic       rx_valid;
  logic [9:0] din;
  logic [7:0] dout [N];
  logic       tv   [N];
`ifdef RAM_PARITY_EN
  logic       perr [N];
`endif

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en   = 0;
  bit lit_mode = 0;
  int lit_q [N][$];

  spi_ram_burst #(.MEM_DEPTH(256), .ADDR_SIZE(8), .DATA_W(8), .AUTO_INC(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .din(din),
    .dout(dout[0]), .tx_valid(tv[0])
`ifdef RAM_PARITY_EN
    , .parity_err(perr[0])
`endif
  );

  spi_ram_burst #(.MEM_DEPTH(256), .ADDR_SIZE(8), .DATA_W(8), .AUTO_INC(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .din(din),
    .dout(dout[1]), .tx_valid(tv[1])
`ifdef RAM_PARITY_EN
    , .parity_err(perr[1])
`endif
  );

  spi_ram_burst #(.MEM_DEPTH(200), .ADDR_SIZE(8), .DATA_W(8), .AUTO_INC(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .din(din),
    .dout(dout[2]), .tx_valid(tv[2])
`ifdef RAM_PARITY_EN
    , .parity_err(perr[2])
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- behavioural reference model ----------------
  function automatic int dep(input int i);
    return (i == 2) ? 200 : 256;
  endfunction

  function automatic bit inc(input int i);
    return (i != 1);
  endfunction

  function automatic int adv(input int p, input int d);
    return (p + 1 >= d) ? 0 : p + 1;
  endfunction

  logic [7:0] m_mem [N][256];
  bit         m_kn  [N][256];
  int         m_wp  [N];
  int         m_rp  [N];
  logic [7:0] e_dout  [N];
  bit         e_tv    [N];
  bit         e_known [N];
`ifdef RAM_PARITY_EN
  bit         m_bad  [N][256];
  bit         e_perr [N];
`endif

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < N; i++) begin
      if (!rst_n) begin
        m_wp[i] = 0; m_rp[i] = 0;
        e_dout[i] = 8'h00; e_tv[i] = 1'b0; e_known[i] = 1'b1;
`ifdef RAM_PARITY_EN
        e_perr[i] = 1'b0;
`endif
      end else begin
        e_tv[i] = 1'b0;
`ifdef RAM_PARITY_EN
        e_perr[i] = 1'b0;
`endif
        if (rx_valid) begin
          case (din[9:8])
            2'b00: m_wp[i] = int'(din[7:0]);
            2'b01: begin
              if (m_wp[i] < dep(i)) begin
                m_mem[i][m_wp[i]] = din[7:0];
                m_kn[i][m_wp[i]]  = 1'b1;
`ifdef RAM_PARITY_EN
                m_bad[i][m_wp[i]] = 1'b0;
`endif
              end
              if (inc(i)) m_wp[i] = adv(m_wp[i], dep(i));
            end
            2'b10: m_rp[i] = int'(din[7:0]);
            default: begin
              e_tv[i] = 1'b1;
              if (m_rp[i] >= dep(i)) begin
                e_dout[i] = 8'h00; e_known[i] = 1'b1;
              end else begin
                e_dout[i]  = m_mem[i][m_rp[i]];
                e_known[i] = m_kn[i][m_rp[i]];
`ifdef RAM_PARITY_EN
                e_perr[i] = m_bad[i][m_rp[i]];
`endif
              end
              if (inc(i)) m_rp[i] = adv(m_rp[i], dep(i));
            end
          endcase
        end
      end
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input int i, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, i, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        for (int i = 0; i < N; i++) begin
          check("tx_valid", i, 32'(tv[i]), 32'(e_tv[i]));
          if (e_known[i]) check("dout", i, 32'(dout[i]), 32'(e_dout[i]));
`ifdef RAM_PARITY_EN
          if (e_known[i]) check("parity_err", i, 32'(perr[i]), 32'(e_perr[i]));
`endif
          if (e_tv[i] && lit_q[i].size() > 0) begin
            int l;
            l = lit_q[i].pop_front();
            if (l >= 0) begin
              check("lit_dout", i, 32'(dout[i]), l);
              check("lit_model", i, 32'(e_dout[i]), l);
            end
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic v, input logic [1:0] op, input logic [7:0] pl,
                       input int l0, input int l1, input int l2);
    @(negedge clk);
    rx_valid = v;
    din      = {op, pl};
    if (v && op == 2'b11 && lit_mode) begin
      lit_q[0].push_back(l0);
      lit_q[1].push_back(l1);
      lit_q[2].push_back(l2);
    end
  endtask

  task automatic cmd(input logic [1:0] op, input logic [7:0] pl);
    drive(1'b1, op, pl, -1, -1, -1);
  endtask

  task automatic rd(input int l0, input int l1, input int l2);
    drive(1'b1, 2'b11, 8'h00, l0, l1, l2);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, 2'b00, 8'h00, -1, -1, -1);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rx_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < N; i++) begin
      check("rst_dout", i, 32'(dout[i]), 0);
      check("rst_tx_valid", i, 32'(tv[i]), 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [1:0] op;
    logic [7:0] pl;
    rst_n = 1'b0; rx_valid = 1'b0; din = '0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < N; i++) begin
      check("reset_dout", i, 32'(dout[i]), 0);
      check("reset_tx_valid", i, 32'(tv[i]), 0);
    end
    rst_n = 1'b1;
    cmp_en = 1'b1;
    lit_mode = 1'b1;

    // burst write/read
    cmd(2'b00, 8'h10);
    cmd(2'b01, 8'hA1); cmd(2'b01, 8'hB2); cmd(2'b01, 8'hC3);
    cmd(2'b10, 8'h10);
    rd(8'hA1, 8'hC3, 8'hA1); rd(8'hB2, 8'hC3, 8'hB2); rd(8'hC3, 8'hC3, 8'hC3);
    idle(2);

    // wrap; dut2 sees 0xFF as out of range
    cmd(2'b00, 8'hFF);
    cmd(2'b01, 8'h11); cmd(2'b01, 8'h22);
    cmd(2'b10, 8'hFF);
    rd(8'h11, 8'h22, 8'h00); rd(8'h22, 8'h22, 8'h22);
    idle(2);

    // hold vs increment
    cmd(2'b00, 8'h05);
    cmd(2'b01, 8'h33); cmd(2'b01, 8'h44);
    cmd(2'b10, 8'h05);
    rd(8'h33, 8'h44, 8'h33); rd(8'h44, 8'h44, 8'h44);
    idle(2);

    // read-after-write, same address
    cmd(2'b10, 8'h40);
    cmd(2'b00, 8'h40);
    cmd(2'b01, 8'h77);
    rd(8'h77, 8'h77, 8'h77);
    idle(2);

    // idle gap carrying a READ opcode
    cmd(2'b10, 8'h10);
    rd(8'hA1, 8'hC3, 8'hA1);
    drive(1'b0, 2'b11, 8'hFF, -1, -1, -1);
    drive(1'b0, 2'b11, 8'h10, -1, -1, -1);
    rd(8'hB2, 8'hC3, 8'hB2);
    idle(2);

    // reset in the cycle after a READ; memory survives
    cmd(2'b10, 8'h05);
    rd(8'h33, 8'h44, 8'h33);
    pulse_reset();
    rd(8'h22, -1, 8'h22);
    idle(2);

`ifdef RAM_PARITY_EN
    cmd(2'b00, 8'h20);
    cmd(2'b01, 8'h5A);
    @(negedge clk);
    rx_valid = 1'b0;
    dut0.r_par[8'h20] = ~dut0.r_par[8'h20];
    m_bad[0][8'h20] = 1'b1;
    cmd(2'b10, 8'h20);
    rd(8'h5A, 8'h5A, 8'h5A);
    @(negedge clk);
    rx_valid = 1'b0;
    check("lit_parity_bad", 0, 32'(perr[0]), 1);
    check("lit_parity_good", 1, 32'(perr[1]), 0);
    cmd(2'b10, 8'h10);
    rd(8'hA1, -1, 8'hA1);
    @(negedge clk);
    rx_valid = 1'b0;
    check("lit_parity_clean", 0, 32'(perr[0]), 0);
    idle(2);
`endif

    lit_mode = 1'b0;

    // fill memory so most random reads have known data
    cmd(2'b00, 8'h00);
    for (int k = 0; k < 256; k++) cmd(2'b01, 8'($urandom));
    idle(1);

    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 299) == 0) begin
        pulse_reset();
      end else begin
        op = 2'($urandom_range(0, 3));
        pl = 8'($urandom);
        if (op == 2'b00 || op == 2'b10)
          pl = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(190, 255))
                                           : 8'($urandom_range(0, 31));
        drive(($urandom_range(0, 3) != 0), op, pl, -1, -1, -1);
      end
    end
    idle(3);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
